// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester block-RAM arbiter (IDLE/ACCESS/RESP), registered RAM drive.
// Optional DMEM_ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests instead of fixed r0 priority.
module dmem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state;
  logic              win;
  logic              pick;
  logic [DATA_W-1:0] r0_rdata_q;
  logic [DATA_W-1:0] r1_rdata_q;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_win;

  always_comb begin
    pick = 1'b1;
    if (r0_req && r1_req) pick = ~last_win;
    else if (r0_req)      pick = 1'b0;
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset)
      last_win <= 1'b1;
    else if (state == IDLE && (r0_req || r1_req))
      last_win <= pick;
  end
`else
  always_comb begin
    pick = ~r0_req;
  end
`endif

  // RAM data only arrives in the RESP cycle, so it is passed through while rvalid is high and held afterwards.
  assign r0_rdata = r0_rvalid ? mem_rdata : r0_rdata_q;
  assign r1_rdata = r1_rvalid ? mem_rdata : r1_rdata_q;

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      win        <= 1'b1;
      r0_gnt     <= 1'b0;
      r1_gnt     <= 1'b0;
      r0_rvalid  <= 1'b0;
      r1_rvalid  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
    end else begin
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      mem_en    <= 1'b0;
      if (r0_rvalid) r0_rdata_q <= mem_rdata;
      if (r1_rvalid) r1_rdata_q <= mem_rdata;
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            state     <= ACCESS;
            win       <= pick;
            mem_en    <= 1'b1;
            mem_we    <= pick ? r1_we : r0_we;
            mem_addr  <= pick ? r1_addr : r0_addr;
            mem_wdata <= pick ? r1_wdata : r0_wdata;
            r0_gnt    <= ~pick;
            r1_gnt    <= pick;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (mem_we) begin
            state <= IDLE;
          end else begin
            state     <= RESP;
            r0_rvalid <= ~win;
            r1_rvalid <= win;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NC = 1400;

  logic          Clock = 1'b0;
  logic          reset = 1'b1;
  logic          r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] ram [0:31];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock(Clock), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 Clock = ~Clock;

  function automatic logic [DW-1:0] init_word(input int a);
    return (a == 3) ? 32'hDEADBEEF : 32'h1000_0000 + a * 32'h0001_0203;
  endfunction

  // Block-RAM environment with one-cycle read latency
  always @(posedge Clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) ram[i] <= init_word(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: expected events per cycle, pending requests, memory image
  logic          e_gnt0 [NC], e_gnt1 [NC], e_rv0 [NC], e_rv1 [NC], e_en [NC], e_we [NC];
  logic [AW-1:0] e_addr [NC];
  logic [DW-1:0] e_wdata [NC], e_rdata [NC];
  logic [DW-1:0] ref_mem [32];
  logic          p_v [2], p_we [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];
  logic [DW-1:0] hold0, hold1;
  int            cyc, next_sample, last_win;

  task automatic drive();
    r0_req = p_v[0]; r0_we = p_we[0]; r0_addr = p_addr[0]; r0_wdata = p_wdata[0];
    r1_req = p_v[1]; r1_we = p_we[1]; r1_addr = p_addr[1]; r1_wdata = p_wdata[1];
  endtask

  // Leaves the bench at a falling edge with reset released; that cycle is cycle 0
  task automatic reinit();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      p_v[k] = 1'b0; p_we[k] = 1'b0; p_addr[k] = '0; p_wdata[k] = '0;
    end
    drive();
    for (int i = 0; i < NC; i++) begin
      e_gnt0[i] = 0; e_gnt1[i] = 0; e_rv0[i] = 0; e_rv1[i] = 0; e_en[i] = 0; e_we[i] = 0;
      e_addr[i] = '0; e_wdata[i] = '0; e_rdata[i] = '0;
    end
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    hold0 = '0; hold1 = '0;
    cyc = 0; next_sample = 0; last_win = 1;
    repeat (3) @(negedge Clock);
    reset = 1'b0;
  endtask

  // Called at the falling edge of cycle cyc; returns at the falling edge of cycle cyc+1
  task automatic run_cycle(input bit rnd, input int req_pct, input int wr_pct);
    int w;
    int s;
    check("gnt0", r0_gnt, e_gnt0[cyc]);
    check("gnt1", r1_gnt, e_gnt1[cyc]);
    check("rvalid0", r0_rvalid, e_rv0[cyc]);
    check("rvalid1", r1_rvalid, e_rv1[cyc]);
    check("mem_en", mem_en, e_en[cyc]);
    if (e_en[cyc]) begin
      check("mem_we", mem_we, e_we[cyc]);
      check("mem_addr", mem_addr, e_addr[cyc]);
      check("mem_wdata", mem_wdata, e_wdata[cyc]);
    end
    if (e_rv0[cyc]) hold0 = e_rdata[cyc];
    if (e_rv1[cyc]) hold1 = e_rdata[cyc];
    check("rdata0", r0_rdata, hold0);
    check("rdata1", r1_rdata, hold1);
    if (e_gnt0[cyc]) p_v[0] = 1'b0;
    if (e_gnt1[cyc]) p_v[1] = 1'b0;
    if (rnd) begin
      for (int k = 0; k < 2; k++) begin
        if (!p_v[k] && $urandom_range(99) < req_pct) begin
          p_v[k]     = 1'b1;
          p_we[k]    = ($urandom_range(99) < wr_pct);
          p_addr[k]  = AW'($urandom);
          p_wdata[k] = $urandom;
        end
      end
    end
    drive();
    s = cyc + 1;
    if (s >= next_sample && (p_v[0] || p_v[1])) begin
      if (p_v[0] && p_v[1]) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        w = 1 - last_win;
`else
        w = 0;
`endif
      end else begin
        w = p_v[0] ? 0 : 1;
      end
      last_win = w;
      if (w == 0) e_gnt0[s] = 1; else e_gnt1[s] = 1;
      e_en[s] = 1; e_we[s] = p_we[w]; e_addr[s] = p_addr[w]; e_wdata[s] = p_wdata[w];
      if (p_we[w]) begin
        ref_mem[p_addr[w]] = p_wdata[w];
        next_sample = s + 2;
      end else begin
        if (w == 0) e_rv0[s+1] = 1; else e_rv1[s+1] = 1;
        e_rdata[s+1] = ref_mem[p_addr[w]];
        next_sample = s + 3;
      end
    end
    cyc++;
    @(negedge Clock);
  endtask

  initial begin
    // r0 read of address 3
    reinit();
    p_v[0] = 1; p_we[0] = 0; p_addr[0] = 5'd3; p_wdata[0] = '0;
    repeat (5) run_cycle(0, 0, 0);
    check("r0_rdata_deadbeef", r0_rdata, 32'hDEADBEEF);

    // r1 write of address 31, then read it back
    p_v[1] = 1; p_we[1] = 1; p_addr[1] = 5'd31; p_wdata[1] = 32'h12345678;
    repeat (4) run_cycle(0, 0, 0);
    p_v[1] = 1; p_we[1] = 0; p_addr[1] = 5'd31;
    repeat (5) run_cycle(0, 0, 0);
    check("r1_rdata_readback", r1_rdata, 32'h12345678);

    // Both requesters reading continuously
    repeat (40) run_cycle(1, 100, 0);

    // Reset in the ACCESS cycle of an r0 read
    reinit();
    p_v[0] = 1; p_we[0] = 0; p_addr[0] = 5'd5;
    run_cycle(0, 0, 0);
    check("abort_pre_gnt0", r0_gnt, 1'b1);
    check("abort_pre_en", mem_en, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_en", mem_en, 1'b0);
    check("abort_gnt0", r0_gnt, 1'b0);
    check("abort_addr", mem_addr, 5'd0);
    p_v[0] = 0;
    drive();
    repeat (2) @(negedge Clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      check("abort_no_rvalid0", r0_rvalid, 1'b0);
      check("abort_no_gnt0", r0_gnt, 1'b0);
      check("abort_no_en", mem_en, 1'b0);
    end

    // Randomized mixed traffic
    reinit();
    repeat (600) run_cycle(1, 40, 50);
    repeat (400) run_cycle(1, 90, 30);
    repeat (8) run_cycle(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
